// File: rtl/system_worker2_cpu_div_pkg.sv
// Shared types and defaults for the iterative divider.
package system_worker2_cpu_div_pkg;

    localparam int DIV_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        DONE
    } div_state_t;

endpackage

// File: rtl/system_worker2_cpu_div_step.sv
// One restoring shift-subtract step: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, shift the quotient bit in.
module system_worker2_cpu_div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] quo,
    input  logic [W-1:0] dvs,
    output logic [W-1:0] rem_nxt,
    output logic [W-1:0] quo_nxt
);

    logic [W:0] shifted;
    logic       fits;

    assign shifted = {rem, quo[W-1]};
    assign fits    = shifted >= {1'b0, dvs};

    // When the divisor fits, the difference is below dvs, so W bits suffice.
    assign rem_nxt = fits ? (shifted[W-1:0] - dvs) : shifted[W-1:0];
    assign quo_nxt = {quo[W-2:0], fits};

endmodule

// File: rtl/system_worker2_cpu_div_unit.sv
// Multi-cycle restoring divider: IDLE -> PREP -> ITER (DATA_W steps) -> FIX -> DONE.
// Signed operation is compiled in only with SYSTEM_WORKER2_CPU_DIV_SIGNED_EN defined.
module system_worker2_cpu_div_unit
    import system_worker2_cpu_div_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] E_src1,
    input  logic [DATA_W-1:0] E_src2,
    input  logic              E_div_start,
    input  logic              E_div_signed,
    output logic [DATA_W-1:0] M_div_quotient,
    output logic [DATA_W-1:0] M_div_remainder,
    output logic              M_div_done,
    output logic              M_div_busy,
    output logic              M_div_by_zero
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    div_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] src_a, src_b;
    logic [DATA_W-1:0] quo, rem, dvs;
    logic [DATA_W-1:0] quo_nxt, rem_nxt;

`ifdef SYSTEM_WORKER2_CPU_DIV_SIGNED_EN
    logic sgn, q_neg, r_neg;
`else
    logic unused_signed;
    assign unused_signed = E_div_signed;
`endif

    system_worker2_cpu_div_step #(.W(DATA_W)) u_step (
        .rem     (rem),
        .quo     (quo),
        .dvs     (dvs),
        .rem_nxt (rem_nxt),
        .quo_nxt (quo_nxt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            cnt             <= '0;
            src_a           <= '0;
            src_b           <= '0;
            quo             <= '0;
            rem             <= '0;
            dvs             <= '0;
`ifdef SYSTEM_WORKER2_CPU_DIV_SIGNED_EN
            sgn             <= 1'b0;
            q_neg           <= 1'b0;
            r_neg           <= 1'b0;
`endif
            M_div_quotient  <= '0;
            M_div_remainder <= '0;
            M_div_done      <= 1'b0;
            M_div_busy      <= 1'b0;
            M_div_by_zero   <= 1'b0;
        end else begin
            M_div_done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (E_div_start) begin
                        state      <= PREP;
                        src_a      <= E_src1;
                        src_b      <= E_src2;
`ifdef SYSTEM_WORKER2_CPU_DIV_SIGNED_EN
                        sgn        <= E_div_signed;
`endif
                        M_div_busy <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                PREP: begin
`ifdef SYSTEM_WORKER2_CPU_DIV_SIGNED_EN
                    quo   <= (sgn && src_a[DATA_W-1]) ? -src_a : src_a;
                    dvs   <= (sgn && src_b[DATA_W-1]) ? -src_b : src_b;
                    q_neg <= sgn && (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
                    r_neg <= sgn && src_a[DATA_W-1];
`else
                    quo   <= src_a;
                    dvs   <= src_b;
`endif
                    rem   <= '0;
                    cnt   <= '0;
                    state <= ITER;
                end
                ITER: begin
                    quo <= quo_nxt;
                    rem <= rem_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_STEP) state <= FIX;
                end
                FIX: begin
                    // Zero divisor bypasses sign handling: all-ones / original dividend.
                    M_div_by_zero <= (dvs == '0);
                    if (dvs == '0) begin
                        M_div_quotient  <= '1;
                        M_div_remainder <= src_a;
                    end else begin
`ifdef SYSTEM_WORKER2_CPU_DIV_SIGNED_EN
                        M_div_quotient  <= q_neg ? -quo : quo;
                        M_div_remainder <= r_neg ? -rem : rem;
`else
                        M_div_quotient  <= quo;
                        M_div_remainder <= rem;
`endif
                    end
                    M_div_done <= 1'b1;
                    M_div_busy <= 1'b0;
                    state      <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
